// File: rtl/noc_link_fault_collector_if.sv
// rtl/noc_link_fault_collector_if.sv - link error, clear handshake and fault vector bundle
interface noc_link_fault_collector_if #(
    parameter int NODES     = 9,
    parameter int CNT_WIDTH = 4,
    parameter int WIN_WIDTH = 16
);
    localparam int NODE_W = $clog2(NODES);

    logic [NODES-1:0][7:0]  link_err_in;
    logic [NODES-1:0][7:0]  link_mask;
    logic [CNT_WIDTH-1:0]   threshold;
    logic [WIN_WIDTH-1:0]   window_len;
    logic                   clear_valid;
    logic                   clear_all;
    logic [NODE_W-1:0]      clear_node;
    logic                   clear_ready;
    logic [NODES-1:0][7:0]  faults_out;
    logic                   new_fault;

    modport master (
        output link_err_in, link_mask, threshold, window_len,
        output clear_valid, clear_all, clear_node,
        input  clear_ready, faults_out, new_fault
    );

    modport slave (
        input  link_err_in, link_mask, threshold, window_len,
        input  clear_valid, clear_all, clear_node,
        output clear_ready, faults_out, new_fault
    );
endinterface

// File: rtl/noc_link_fault_collector.sv
// rtl/noc_link_fault_collector.sv - windowed per-link error filter producing sticky per-node fault vectors
module noc_link_fault_collector #(
    parameter int X         = 3,
    parameter int Y         = 3,
    parameter int CNT_WIDTH = 4,
    parameter int WIN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_noc,
    noc_link_fault_collector_if.slave bus
);
    localparam int NODES  = X * Y;
    localparam int NODE_W = $clog2(NODES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    logic [NODES-1:0][7:0]                 err_q;
    logic [NODES-1:0][7:0][CNT_WIDTH-1:0]  cnt;
    logic [NODES-1:0][7:0][CNT_WIDTH-1:0]  cnt_next;
    logic [NODES-1:0][7:0]                 faults;
    logic [NODES-1:0][7:0]                 faults_prev;
    logic [NODES-1:0][7:0]                 faults_next;
    logic [WIN_WIDTH-1:0]                  win_cnt;
    logic [WIN_WIDTH-1:0]                  win_cnt_next;
    logic [NODES-1:0]                      clear_sel;
    logic [CNT_WIDTH-1:0]                  thr_eff;
    logic                                  win_end;
    logic                                  clear_acc;
    logic                                  clear_ready_q;
    logic                                  new_fault_q;

    always_comb begin
        thr_eff   = (bus.threshold == '0) ? CNT_ONE : bus.threshold;
        clear_acc = bus.clear_valid & clear_ready_q;
        // A shrunken window (win_cnt already past the end) also closes here.
        win_end   = (bus.window_len != '0) && (win_cnt >= bus.window_len - WIN_ONE);
        win_cnt_next = ((bus.window_len == '0) || win_end) ? '0 : win_cnt + WIN_ONE;

        cnt_next    = cnt;
        faults_next = faults;
        clear_sel   = '0;
        for (int n = 0; n < NODES; n++) begin
            clear_sel[n] = clear_acc & (bus.clear_all | (bus.clear_node == NODE_W'(n)));
            for (int l = 0; l < 8; l++) begin
                if (clear_sel[n]) begin
                    cnt_next[n][l] = err_q[n][l] ? CNT_ONE : '0;
                end else if (faults[n][l]) begin
                    cnt_next[n][l] = cnt[n][l];
                end else if (win_end) begin
                    cnt_next[n][l] = err_q[n][l] ? CNT_ONE : '0;
                end else if (err_q[n][l] && (cnt[n][l] != CNT_MAX)) begin
                    cnt_next[n][l] = cnt[n][l] + CNT_ONE;
                end
                // A fresh error reaching threshold beats a simultaneous clear.
                if (clear_sel[n]) begin
                    faults_next[n][l] = (cnt_next[n][l] >= thr_eff);
                end else begin
                    faults_next[n][l] = faults[n][l] | (cnt_next[n][l] >= thr_eff);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_noc) begin
            err_q         <= '0;
            cnt           <= '0;
            faults        <= '0;
            faults_prev   <= '0;
            win_cnt       <= '0;
            clear_ready_q <= 1'b0;
            new_fault_q   <= 1'b0;
        end else begin
            err_q         <= bus.link_err_in & ~bus.link_mask;
            cnt           <= cnt_next;
            faults        <= faults_next;
            faults_prev   <= faults;
            win_cnt       <= win_cnt_next;
            clear_ready_q <= ~clear_acc;
            new_fault_q   <= |(faults & ~faults_prev);
        end
    end

    assign bus.faults_out  = faults;
    assign bus.new_fault   = new_fault_q;
    assign bus.clear_ready = clear_ready_q;

endmodule

// File: tb/tb_noc_link_fault_collector.sv
// tb/tb_noc_link_fault_collector.sv - directed and randomized checks against a rule-level fault model
module tb_noc_link_fault_collector;
    localparam int N = 9;

    logic clk = 1'b0;
    logic rst_noc = 1'b1;
    always #5 clk = ~clk;

    noc_link_fault_collector_if #(.NODES(N), .CNT_WIDTH(4), .WIN_WIDTH(16)) bus ();

    noc_link_fault_collector #(.X(3), .Y(3), .CNT_WIDTH(4), .WIN_WIDTH(16)) dut (
        .clk     (clk),
        .rst_noc (rst_noc),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int nf_pulses = 0;

    int m_cnt  [N][8];
    bit m_flt  [N][8];
    bit m_prev [N][8];
    bit m_err  [N][8];
    bit m_rdy;
    bit m_nf;
    int m_pos;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [N*8-1:0] exp_faults();
        logic [N*8-1:0] v = '0;
        for (int n = 0; n < N; n++)
            for (int l = 0; l < 8; l++)
                v[n*8+l] = m_flt[n][l];
        return v;
    endfunction

    // Applies one clock edge's worth of the filtering rules to the model.
    task automatic model_edge();
        bit acc, wend, hit, any_new;
        int thr, len, c;
        bit nflt [N][8];
        if (rst_noc) begin
            for (int n = 0; n < N; n++)
                for (int l = 0; l < 8; l++) begin
                    m_cnt[n][l] = 0; m_flt[n][l] = 0; m_prev[n][l] = 0; m_err[n][l] = 0;
                end
            m_rdy = 0; m_nf = 0; m_pos = 0;
            return;
        end
        acc = bus.clear_valid && m_rdy;
        thr = (bus.threshold == 0) ? 1 : int'(bus.threshold);
        len = int'(bus.window_len);
        wend = (len != 0) && (m_pos >= len - 1);
        any_new = 0;
        for (int n = 0; n < N; n++)
            for (int l = 0; l < 8; l++) begin
                hit = acc && (bus.clear_all || int'(bus.clear_node) == n);
                c = m_cnt[n][l];
                if (hit) c = m_err[n][l] ? 1 : 0;
                else if (m_flt[n][l]) c = c;
                else if (wend) c = m_err[n][l] ? 1 : 0;
                else if (m_err[n][l]) c = (c < 15) ? c + 1 : 15;
                m_cnt[n][l] = c;
                nflt[n][l] = hit ? (c >= thr) : (m_flt[n][l] || c >= thr);
                if (m_flt[n][l] && !m_prev[n][l]) any_new = 1;
            end
        m_nf = any_new;
        for (int n = 0; n < N; n++)
            for (int l = 0; l < 8; l++) begin
                m_prev[n][l] = m_flt[n][l];
                m_flt[n][l]  = nflt[n][l];
                m_err[n][l]  = bus.link_err_in[n][l] && !bus.link_mask[n][l];
            end
        m_pos = (len == 0 || wend) ? 0 : m_pos + 1;
        m_rdy = !acc;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("faults_out", bus.faults_out, exp_faults());
        check("new_fault", bus.new_fault, m_nf);
        check("clear_ready", bus.clear_ready, m_rdy);
        if (bus.new_fault) nf_pulses++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic do_reset();
        rst_noc = 1'b1;
        idle(2);
        rst_noc = 1'b0;
    endtask

    task automatic do_strobe(input int n, input int l);
        bus.link_err_in[n][l] = 1'b1;
        cycle();
        bus.link_err_in[n][l] = 1'b0;
    endtask

    task automatic do_clear(input bit all, input int node);
        bit done = 0;
        bus.clear_valid = 1'b1;
        bus.clear_all   = all;
        bus.clear_node  = 4'(node);
        for (int i = 0; i < 4 && !done; i++) begin
            done = bus.clear_ready;
            cycle();
        end
        bus.clear_valid = 1'b0;
        check("clear_accepted", done, 1);
    endtask

    initial begin
        bus.link_err_in = '0;
        bus.link_mask   = '0;
        bus.threshold   = 4'd1;
        bus.window_len  = 16'd0;
        bus.clear_valid = 1'b0;
        bus.clear_all   = 1'b0;
        bus.clear_node  = '0;

        // Reset state, then single strobe latency and pulse timing.
        do_reset();
        check("rst_faults", bus.faults_out, 0);
        check("rst_ready", bus.clear_ready, 0);
        cycle();
        check("ready_after_rst", bus.clear_ready, 1);
        idle(7);
        do_strobe(4, 2);
        check("t1_not_yet", bus.faults_out, 0);
        cycle();
        check("t1_node4", bus.faults_out[4], 8'h04);
        check("t1_others", bus.faults_out & ~(72'hFF << 32), 0);
        check("t1_nf_early", bus.new_fault, 0);
        cycle();
        check("t1_nf_pulse", bus.new_fault, 1);
        cycle();
        check("t1_nf_end", bus.new_fault, 0);

        // Threshold 3 over a 100-cycle window.
        bus.threshold = 4'd3; bus.window_len = 16'd100;
        do_reset();
        idle(10); do_strobe(0, 0); idle(10); do_strobe(0, 0);
        idle(100);
        check("t2_window_reset", bus.faults_out[0], 8'h00);
        do_strobe(0, 0); idle(3); do_strobe(0, 0); idle(3); do_strobe(0, 0);
        check("t2_third_pending", bus.faults_out[0][0], 0);
        cycle();
        check("t2_fault", bus.faults_out[0][0], 1);

        // Threshold 0 acts as 1; masked links never count.
        bus.threshold = 4'd0; bus.window_len = 16'd0;
        do_reset();
        bus.link_mask[1] = 8'hFF;
        bus.link_err_in[1] = 8'hFF; cycle(); bus.link_err_in[1] = 8'h00;
        idle(3);
        check("t3_masked", bus.faults_out[1], 8'h00);
        bus.link_mask[1] = 8'h00;
        do_strobe(1, 5); idle(2);
        check("t3_unmasked", bus.faults_out[1], 8'h20);

        // Single-node clear, throttle, then clear-all.
        bus.threshold = 4'd1;
        do_reset();
        bus.link_err_in[2][0] = 1'b1; bus.link_err_in[5][3] = 1'b1;
        cycle();
        bus.link_err_in = '0;
        idle(3);
        do_clear(0, 2);
        check("t4_node2", bus.faults_out[2], 8'h00);
        check("t4_node5", bus.faults_out[5], 8'h08);
        check("t4_throttle", bus.clear_ready, 0);
        cycle();
        check("t4_ready_back", bus.clear_ready, 1);
        do_clear(1, 0);
        check("t4_all_zero", bus.faults_out, 0);

        // Clear landing on the same edge as a counted error: set wins.
        idle(2);
        do_strobe(3, 1); idle(3);
        do_strobe(3, 1);
        do_clear(0, 3);
        check("t5_set_wins", bus.faults_out[3][1], 1);
        do_clear(0, 3);
        check("t5_cleared", bus.faults_out[3][1], 0);
        do_clear(0, 12);

        // Saturation at 15 with a single pulse, then reset mid-stream.
        bus.threshold = 4'd15; bus.window_len = 16'd0;
        do_reset();
        nf_pulses = 0;
        for (int i = 0; i < 20; i++) begin do_strobe(7, 6); cycle(); end
        idle(3);
        check("t6_fault", bus.faults_out[7][6], 1);
        check("t6_one_pulse", nf_pulses, 1);
        do_strobe(7, 6);
        rst_noc = 1'b1;
        bus.clear_valid = 1'b1; bus.clear_all = 1'b1;
        cycle();
        check("t6_rst_faults", bus.faults_out, 0);
        check("t6_rst_ready", bus.clear_ready, 0);
        check("t6_rst_nf", bus.new_fault, 0);
        rst_noc = 1'b0;
        cycle();
        cycle();
        bus.clear_valid = 1'b0;

        // Randomized phases with clears, window changes and resets.
        for (int ph = 0; ph < 6; ph++) begin
            bus.threshold  = 4'($urandom_range(0, (ph == 5) ? 15 : 4));
            bus.window_len = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 40));
            for (int n = 0; n < N; n++)
                bus.link_mask[n] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            for (int c = 0; c < 400; c++) begin
                bit acc_now;
                for (int n = 0; n < N; n++)
                    for (int l = 0; l < 8; l++)
                        bus.link_err_in[n][l] = ($urandom_range(0, 199) < 3);
                if (!bus.clear_valid && $urandom_range(0, 15) == 0) begin
                    bus.clear_valid = 1'b1;
                    bus.clear_all   = ($urandom_range(0, 3) == 0);
                    bus.clear_node  = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 99) == 0) bus.window_len = 16'($urandom_range(0, 20));
                rst_noc = ($urandom_range(0, 299) == 0);
                acc_now = bus.clear_valid && bus.clear_ready && !rst_noc;
                cycle();
                if (acc_now) bus.clear_valid = 1'b0;
            end
        end
        rst_noc = 1'b0;
        bus.link_err_in = '0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
